// File: rtl/global_list_relay_pkg.sv
// Shared types and helpers for the list relay: drain modes, handshake states
// and index sizing.
package global_list_relay_pkg;

  localparam int MAX_DEPTH = 64;

  typedef enum logic [1:0] {
    RELAY_FIFO = 2'd0,
    RELAY_LIFO = 2'd1,
    RELAY_SUM  = 2'd2
  } relay_mode_e;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } relay_state_e;

  // Index width that stays at least one bit wide for a single-entry list.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/relay_list_store.sv
// DEPTH x DATA_W list register with one write port, two combinational read
// ports and the running sum of every element except the last slot.
module relay_list_store
  import global_list_relay_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 5,
  parameter int IDX_W  = idx_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [IDX_W-1:0]  i_rd_idx_a,
  input  logic [IDX_W-1:0]  i_rd_idx_b,
  output logic [DATA_W-1:0] o_rd_data_a,
  output logic [DATA_W-1:0] o_rd_data_b,
  output logic [DATA_W-1:0] o_prefix_sum
);

  logic [DATA_W-1:0] r_list [DEPTH];

  // NOTE: storage arrays are normally left unreset; this one is cleared because
  // the list must read back as all zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_list[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_wr_en && (i_wr_idx == IDX_W'(i))) r_list[i] <= i_wr_data;
      end
    end
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it holding a value (no latch).
  always_comb begin
    o_rd_data_a = '0;
    o_rd_data_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_rd_idx_a == IDX_W'(i)) o_rd_data_a = r_list[i];
      if (i_rd_idx_b == IDX_W'(i)) o_rd_data_b = r_list[i];
    end
  end

  // NOTE: the accumulator uses blocking '=' because each iteration must see the
  // previous partial sum; registered state elsewhere uses '<=' only.
  // The final slot is excluded: its word is still on i_wr_data when the sum is used.
  always_comb begin
    o_prefix_sum = '0;
    for (int i = 0; i < DEPTH - 1; i++) o_prefix_sum = o_prefix_sum + r_list[i];
  end

endmodule

// File: rtl/global_list_relay.sv
// Blocking-port list relay: fills DEPTH words from the input handshake, then
// drains them in FIFO order, LIFO order or as one modular sum.
module global_list_relay
  import global_list_relay_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 5,
  parameter int MODE   = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_sync,
  output logic                       in_notify,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       out_sync,
  output logic                       out_notify,
  output logic                       out_last,
  output logic [$clog2(DEPTH+1)-1:0] fill_level
);

  localparam int               IDX_W         = idx_width(DEPTH);
  localparam int               FL_W          = $clog2(DEPTH + 1);
  localparam relay_mode_e      MODE_E        = relay_mode_e'(2'(MODE));
  localparam logic [IDX_W-1:0] LAST_IDX      = IDX_W'(DEPTH - 1);
  localparam logic             FIRST_IS_LAST = (MODE_E == RELAY_SUM) || (DEPTH == 1);

  if (MODE < 0 || MODE > 2) begin : g_bad_mode
    $error("global_list_relay: MODE must be 0, 1 or 2");
  end
  if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
    $error("global_list_relay: DEPTH must be within 1..64");
  end

  relay_state_e      r_state;
  logic [IDX_W-1:0]  r_wr_idx;
  logic [IDX_W-1:0]  r_rd_idx;
  logic [FL_W-1:0]   r_fill_level;
  logic              r_in_notify;
  logic              r_out_notify;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_last;

  logic              w_in_xfer;
  logic              w_out_xfer;
  logic [IDX_W-1:0]  w_fifo_addr;
  logic [IDX_W-1:0]  w_lifo_addr;
  logic [DATA_W-1:0] w_rd_fifo;
  logic [DATA_W-1:0] w_rd_lifo;
  logic [DATA_W-1:0] w_prefix_sum;
  logic [DATA_W-1:0] w_first_word;
  logic [DATA_W-1:0] w_next_word;

  assign w_in_xfer  = r_in_notify && in_sync;
  assign w_out_xfer = r_out_notify && out_sync;

  // While filling, port A points at element 0 so the FIFO head is ready for the final edge.
  assign w_fifo_addr = (r_state == FILL) ? '0 : r_rd_idx + IDX_W'(1);
  assign w_lifo_addr = LAST_IDX - r_rd_idx - IDX_W'(1);

  relay_list_store #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_store (
    .clk          (clk),
    .rst          (rst),
    .i_wr_en      (w_in_xfer),
    .i_wr_idx     (r_wr_idx),
    .i_wr_data    (in_data),
    .i_rd_idx_a   (w_fifo_addr),
    .i_rd_idx_b   (w_lifo_addr),
    .o_rd_data_a  (w_rd_fifo),
    .o_rd_data_b  (w_rd_lifo),
    .o_prefix_sum (w_prefix_sum)
  );

  always_comb begin
    w_first_word = in_data;
    w_next_word  = w_rd_fifo;
    case (MODE_E)
      RELAY_FIFO: w_first_word = (DEPTH == 1) ? in_data : w_rd_fifo;
      RELAY_LIFO: begin
        w_first_word = in_data;
        w_next_word  = w_rd_lifo;
      end
      default:    w_first_word = w_prefix_sum + in_data;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= FILL;
      r_wr_idx     <= '0;
      r_rd_idx     <= '0;
      r_fill_level <= '0;
      r_in_notify  <= 1'b1;
      r_out_notify <= 1'b0;
      r_out_data   <= '0;
      r_out_last   <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_in_xfer) begin
            r_fill_level <= r_fill_level + FL_W'(1);
            if (r_wr_idx == LAST_IDX) begin
              r_state      <= DRAIN;
              r_in_notify  <= 1'b0;
              r_out_notify <= 1'b1;
              r_out_data   <= w_first_word;
              r_out_last   <= FIRST_IS_LAST;
            end else begin
              r_wr_idx <= r_wr_idx + IDX_W'(1);
            end
          end
        end
        DRAIN: begin
          if (w_out_xfer) begin
            if (!r_out_last) begin
              r_rd_idx   <= r_rd_idx + IDX_W'(1);
              r_out_data <= w_next_word;
              r_out_last <= (r_rd_idx + IDX_W'(1) == LAST_IDX);
            end else begin
              r_state      <= FILL;
              r_out_notify <= 1'b0;
              r_in_notify  <= 1'b1;
              r_wr_idx     <= '0;
              r_rd_idx     <= '0;
              r_fill_level <= '0;
              r_out_last   <= 1'b0;
            end
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign in_notify  = r_in_notify;
  assign out_notify = r_out_notify;
  assign out_data   = r_out_data;
  assign out_last   = r_out_last;
  assign fill_level = r_fill_level;

endmodule

// File: tb/tb_global_list_relay.sv
// Bench for global_list_relay: four parameter sets run side by side, each with a
// queue-based reference model checked every cycle plus pinned directed results.
module tb_global_list_relay;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit done [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int DW    = (g == 2) ? 8 : 32;
    localparam int DEPTH = (g == 2) ? 3 : ((g == 3) ? 1 : 5);
    localparam int MODE  = (g == 1) ? 1 : ((g == 2) ? 2 : 0);
    localparam int FLW   = $clog2(DEPTH + 1);
    // Hand-computed results of the first (directed) batch of each configuration.
    localparam logic [31:0] EXP_FIRST = (g == 0) ? 32'd1 : (g == 1) ? 32'd50 :
                                        (g == 2) ? 32'd51 : 32'hDEAD_BEEF;
    localparam logic [31:0] EXP_LAST  = (g == 0) ? 32'd5 : (g == 1) ? 32'd10 :
                                        (g == 2) ? 32'd51 : 32'hDEAD_BEEF;
    localparam int          EXP_NW    = (g < 2) ? 5 : 1;

    logic           rst;
    logic [DW-1:0]  in_data;
    logic           in_sync;
    logic           in_notify;
    logic [DW-1:0]  out_data;
    logic           out_sync;
    logic           out_notify;
    logic           out_last;
    logic [FLW-1:0] fill_level;

    global_list_relay #(
      .DATA_W (DW),
      .DEPTH  (DEPTH),
      .MODE   (MODE)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_sync    (in_sync),
      .in_notify  (in_notify),
      .out_data   (out_data),
      .out_sync   (out_sync),
      .out_notify (out_notify),
      .out_last   (out_last),
      .fill_level (fill_level)
    );

    // Reference model: a batch queue filled word by word, and a drain queue built
    // from the whole batch once it is complete.
    logic [DW-1:0] batch_q [$];
    logic [DW-1:0] drain_q [$];
    logic [DW-1:0] m_last;
    bit            m_drain;

    always @(posedge clk or posedge rst) begin : model
      logic [DW-1:0] s;
      if (rst) begin
        batch_q.delete();
        drain_q.delete();
        m_drain = 1'b0;
        m_last  = '0;
      end else if (!m_drain) begin
        if (in_sync) begin
          batch_q.push_back(in_data);
          if (batch_q.size() == DEPTH) begin
            drain_q.delete();
            if (MODE == 0) begin
              drain_q = batch_q;
            end else if (MODE == 1) begin
              for (int i = DEPTH - 1; i >= 0; i--) drain_q.push_back(batch_q[i]);
            end else begin
              s = '0;
              foreach (batch_q[i]) s = s + batch_q[i];
              drain_q.push_back(s);
            end
            m_drain = 1'b1;
          end
        end
      end else if (out_sync) begin
        m_last = drain_q.pop_front();
        if (drain_q.size() == 0) begin
          m_drain = 1'b0;
          batch_q.delete();
        end
      end
    end

    always @(negedge clk) begin
      check($sformatf("cfg%0d in_notify", g), 64'(in_notify), 64'(!m_drain));
      check($sformatf("cfg%0d out_notify", g), 64'(out_notify), 64'(m_drain));
      check($sformatf("cfg%0d fill_level", g), 64'(fill_level), 64'(batch_q.size()));
      check($sformatf("cfg%0d out_last", g), 64'(out_last),
            64'(m_drain && (drain_q.size() == 1)));
      if (m_drain) check($sformatf("cfg%0d out_data", g), 64'(out_data), 64'(drain_q[0]));
      else         check($sformatf("cfg%0d out_data_hold", g), 64'(out_data), 64'(m_last));
    end

    function automatic logic [DW-1:0] dir_word(input int i);
      case (g)
        0:       return DW'(i + 1);
        1:       return DW'(10 * (i + 1));
        2:       return (i == 0) ? DW'(200) : ((i == 1) ? DW'(100) : DW'(7));
        default: return DW'(32'hDEAD_BEEF);
      endcase
    endfunction

    // Pushes DEPTH words back to back; caller guarantees the block is filling.
    task automatic push_batch(input bit directed);
      for (int i = 0; i < DEPTH; i++) begin
        in_data = directed ? dir_word(i) : DW'($urandom);
        in_sync = 1'b1;
        @(posedge clk);
        #1;
      end
      in_sync = 1'b0;
    endtask

    task automatic drain_all(output int n, output logic [DW-1:0] first, output logic [DW-1:0] last);
      n        = 0;
      first    = '0;
      last     = '0;
      out_sync = 1'b1;
      while (out_notify && n < 100) begin
        if (n == 0) first = out_data;
        last = out_data;
        n++;
        @(posedge clk);
        #1;
      end
    endtask

    initial begin : stim
      int            n;
      logic [DW-1:0] first;
      logic [DW-1:0] last;
      rst      = 1'b1;
      in_sync  = 1'b0;
      out_sync = 1'b0;
      in_data  = '0;
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("cfg%0d rst in_notify", g), 64'(in_notify), 64'(1));
      check($sformatf("cfg%0d rst out_notify", g), 64'(out_notify), 64'(0));
      check($sformatf("cfg%0d rst out_data", g), 64'(out_data), 64'(0));
      check($sformatf("cfg%0d rst out_last", g), 64'(out_last), 64'(0));
      check($sformatf("cfg%0d rst fill_level", g), 64'(fill_level), 64'(0));
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Directed batch with both partners always ready.
      out_sync = 1'b1;
      push_batch(1'b1);
      check($sformatf("cfg%0d full in_notify", g), 64'(in_notify), 64'(0));
      check($sformatf("cfg%0d first out_notify", g), 64'(out_notify), 64'(1));
      check($sformatf("cfg%0d first word", g), 64'(out_data), 64'(EXP_FIRST));
      check($sformatf("cfg%0d first out_last", g), 64'(out_last), 64'(EXP_NW == 1));
      drain_all(n, first, last);
      check($sformatf("cfg%0d word count", g), 64'(n), 64'(EXP_NW));
      check($sformatf("cfg%0d drained first", g), 64'(first), 64'(EXP_FIRST));
      check($sformatf("cfg%0d drained last", g), 64'(last), 64'(EXP_LAST));
      check($sformatf("cfg%0d refill notify", g), 64'(in_notify), 64'(1));

      // Backpressure: receiver stalls, sender keeps pulsing sync.
      out_sync = 1'b0;
      push_batch(1'b0);
      for (int c = 0; c < 10; c++) begin
        in_sync = 1'($urandom_range(0, 1));
        in_data = DW'($urandom);
        @(posedge clk);
        #1;
        check($sformatf("cfg%0d stall fill_level", g), 64'(fill_level), 64'(DEPTH));
        check($sformatf("cfg%0d stall out_notify", g), 64'(out_notify), 64'(1));
        check($sformatf("cfg%0d stall in_notify", g), 64'(in_notify), 64'(0));
      end
      in_sync = 1'b0;
      drain_all(n, first, last);
      check($sformatf("cfg%0d stall word count", g), 64'(n), 64'(EXP_NW));

      // Asynchronous reset in the middle of a drain.
      out_sync = 1'b0;
      push_batch(1'b0);
      out_sync = 1'b1;
      repeat ((EXP_NW > 2) ? 2 : 0) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check($sformatf("cfg%0d arst out_notify", g), 64'(out_notify), 64'(0));
      check($sformatf("cfg%0d arst in_notify", g), 64'(in_notify), 64'(1));
      check($sformatf("cfg%0d arst fill_level", g), 64'(fill_level), 64'(0));
      check($sformatf("cfg%0d arst out_data", g), 64'(out_data), 64'(0));
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      push_batch(1'b0);
      drain_all(n, first, last);
      check($sformatf("cfg%0d post-reset count", g), 64'(n), 64'(EXP_NW));

      // Randomized traffic on both handshakes.
      for (int c = 0; c < 400; c++) begin
        in_sync  = ($urandom_range(0, 3) != 0);
        out_sync = ($urandom_range(0, 2) != 0);
        in_data  = DW'($urandom);
        @(posedge clk);
        #1;
      end
      in_sync  = 1'b0;
      out_sync = 1'b0;
      done[g]  = 1'b1;
    end
  end

  initial begin : finisher
    int cyc;
    cyc = 0;
    while (!(done[0] && done[1] && done[2] && done[3]) && cyc < 20000) begin
      @(posedge clk);
      cyc++;
    end
    check("run completes", 64'(done[0] && done[1] && done[2] && done[3]), 64'(1));
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
